noc_rr_arbiter: RTL
===================

// Module: noc_rr_arbiter
// PURPOSE
//  N-input output-port arbiter for the NoC router; successor to the fixed 5-port arbiter.
//  Grants one input port at a time with round-robin priority.
//  Each port's grant tenure is bounded by a per-port timer, loaded from the packet length carried on the header flit.
//  Grant is registered, one-hot, and drives the crossbar select for one output port.
// PARAMETERS
//  NUM_PORTS  5       number of requesting input ports (>=2)
//  LEN_W      12      width of packet length / tenure limit
//  ID_W       3       width of flit_id field
//  HEADER_ID  3'b001  flit_id value marking a header flit (loads tenure limit)
//  IDX_W      $clog2(NUM_PORTS)  width of grant_idx (derived, not overridable)
// PORTS
//  clk            in   1                  clock, all state on posedge
//  rst            in   1                  synchronous, active-high reset
//  req            in   NUM_PORTS          per-port request, level
//  flit_id        in   NUM_PORTS*ID_W     per-port flit type; port i at [i*ID_W +: ID_W]
//  length         in   NUM_PORTS*LEN_W    per-port packet length; port i at [i*LEN_W +: LEN_W]
//  grant          out  NUM_PORTS          registered one-hot grant, all-zero = idle
//  grant_valid    out  1                  |grant
//  grant_idx      out  IDX_W              binary index of granted port; 0 when idle
//  timeout_pulse  out  NUM_PORTS          1-cycle pulse: port i lost grant by expiry while req[i]=1
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - grant, grant_idx, grant_valid and timeout_pulse clear to 0.
//   - Every timer's count and limit clear to 0.
//   - RR pointer resets to NUM_PORTS-1, so port 0 has first priority.
//   - Takes effect mid-tenure, with no completion of the current grant.
//  States: IDLE (grant==0) and HOLD(i) (grant[i]==1); state is encoded by grant itself.
//  Timer per port:
//   - limit <= length[i] on any cycle where flit_id[i]==HEADER_ID, independent of grant; a new limit is used from the next cycle.
//   - count clears when grant[i]==0 and increments by 1 each cycle grant[i]==1.
//   - expired[i] = ({1'b0,count}+1 >= {1'b0,limit}), evaluated in LEN_W+1 bits, so no wrap.
//   - Tenure is max(limit,1) cycles; limit 0 behaves as 1.
//  Next-grant decision, combinational from the current state, registered at posedge:
//   - IDLE: pick the first req[j]=1 scanning j = ptr+1, ptr+2, ... modulo NUM_PORTS; if none, stay IDLE.
//   - HOLD(i), req[i]=1 and !expired[i]: keep i.
//   - HOLD(i), otherwise: scan from i+1 modulo NUM_PORTS, including i last.
//   - In that scan, i is eligible only if req[i]=1 and it did not expire; an expired port is skipped this cycle.
//   - If no port is eligible, go IDLE.
//  ptr <= index of granted port whenever a new grant is issued.
//  timeout_pulse[i] is registered with the grant change: it asserts in the cycle grant[i] falls, if the cause was expiry with req[i]=1.
//  Latency:
//   - req rise at cycle t gives grant at t+1 when idle.
//   - A release at t hands over directly to the next port at t+1, with no idle bubble.
//  Invariant: grant is always one-hot or zero. A grant to a port with req=0 never occurs.
//  Simultaneous header load and expiry on the same cycle: expiry uses the old limit.
// STRUCTURE
//  Shared package noc_pkg:
//   - HEADER_ID, BODY_ID and TAIL_ID flit-type constants.
//   - flit_id_t typedef.
//   - Default NUM_PORTS and LEN_W.
//  Sub-module arb_port_timer (LEN_W, ID_W, HEADER_ID):
//   - Inputs clk, rst, flit_id, length, run.
//   - Output expired.
//   - Instantiated NUM_PORTS times in a generate loop.
//  Top level holds the RR scan function, the grant register and the pointer register.
// TESTING
//  1. Reset, then req=5'b10110, all limits 10, hold reqs:
//     grant 5'b00010 first, then 5'b00100, then 5'b10000, each for 10 cycles, then back to 5'b00010.
//  2. Port 2 header with length=3, req[2] alone held:
//     grant[2] high 3 cycles, timeout_pulse[2] on the fall, regranted the next cycle (only requester), count restarts.
//  3. Length 0 on port 1 with req[1],req[3] held:
//     grant alternates 5'b00010 (1 cycle) and 5'b01000 (limit cycles), with no idle cycles between them.
//  4. Port 0 holding (limit 100), req[0] drops at cycle 20:
//     next cycle grants the next requester after port 0; timeout_pulse stays 0.
//  5. rst asserted mid-tenure of port 3:
//     grant=0 next cycle; after release, req=all ones gives port 0 first.
//  6. Random req/flit_id for 10k cycles:
//     - Assert one-hot-or-zero grant.
//     - Assert grant implies req.
//     - Assert no tenure exceeds max(limit,1).
//     - Assert no starvation: any port with req held is granted within NUM_PORTS*max_limit cycles.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit-type encodings and default router geometry.
package noc_pkg;

  localparam int NOC_NUM_PORTS = 5;
  localparam int NOC_LEN_W     = 12;
  localparam int NOC_ID_W      = 3;

  typedef logic [NOC_ID_W-1:0] flit_id_t;

  localparam flit_id_t HEADER_ID = 3'b001;
  localparam flit_id_t BODY_ID   = 3'b010;
  localparam flit_id_t TAIL_ID   = 3'b100;

endpackage

// File: rtl/noc_rr_arbiter_if.sv
// Request/grant bundle between the input ports and one output-port arbiter.
interface noc_rr_arbiter_if #(
  parameter int NUM_PORTS = noc_pkg::NOC_NUM_PORTS,
  parameter int LEN_W     = noc_pkg::NOC_LEN_W,
  parameter int ID_W      = noc_pkg::NOC_ID_W
);
  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]      req;
  logic [NUM_PORTS*ID_W-1:0] flit_id;
  logic [NUM_PORTS*LEN_W-1:0] length;
  logic [NUM_PORTS-1:0]      grant;
  logic                      grant_valid;
  logic [IDX_W-1:0]          grant_idx;
  logic [NUM_PORTS-1:0]      timeout_pulse;

  modport master (
    output req, flit_id, length,
    input  grant, grant_valid, grant_idx, timeout_pulse
  );

  modport slave (
    input  req, flit_id, length,
    output grant, grant_valid, grant_idx, timeout_pulse
  );
endinterface

// File: rtl/arb_port_timer.sv
// Per-port tenure timer: latches the packet length from header flits and
// flags expiry once the port has held the grant for max(limit,1) cycles.
module arb_port_timer
  import noc_pkg::*;
#(
  parameter int              LEN_W     = NOC_LEN_W,
  parameter int              ID_W      = NOC_ID_W,
  parameter logic [ID_W-1:0] HEADER_ID = noc_pkg::HEADER_ID
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ID_W-1:0]  flit_id,
  input  logic [LEN_W-1:0] length,
  input  logic             run,
  output logic             expired
);

  logic [LEN_W-1:0] count_q, count_d;
  logic [LEN_W-1:0] limit_q, limit_d;
  logic [LEN_W:0]   count_inc;

  always_comb begin
    count_d = run ? count_q + LEN_W'(1) : '0;
    limit_d = (flit_id == HEADER_ID) ? length : limit_q;
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values and simulation ordering matches the synthesized flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      limit_q <= '0;
    end else begin
      count_q <= count_d;
      limit_q <= limit_d;
    end
  end

  // One extra bit keeps count+1 from wrapping when limit is all-ones.
  assign count_inc = {1'b0, count_q} + (LEN_W+1)'(1);
  assign expired   = count_inc >= {1'b0, limit_q};

endmodule

// File: rtl/noc_rr_arbiter.sv
// Round-robin output-port arbiter with per-port tenure limits; the registered
// one-hot grant is the arbiter state and drives the crossbar select.
module noc_rr_arbiter
  import noc_pkg::*;
#(
  parameter int              NUM_PORTS = NOC_NUM_PORTS,
  parameter int              LEN_W     = NOC_LEN_W,
  parameter int              ID_W      = NOC_ID_W,
  parameter logic [ID_W-1:0] HEADER_ID = noc_pkg::HEADER_ID
) (
  input  logic             clk,
  input  logic             rst,
  noc_rr_arbiter_if.slave  bus
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef logic [NUM_PORTS-1:0] vec_t;
  typedef logic [IDX_W-1:0]     idx_t;

  vec_t grant_q, grant_d;
  vec_t timeout_q, timeout_d;
  idx_t ptr_q, ptr_d;
  vec_t expired, elig;
  idx_t pick;
  logic found, keep;

  // First eligible port after 'start', wrapping, with 'start' itself last.
  function automatic logic [IDX_W:0] rr_pick(input vec_t e, input idx_t start);
    logic           hit;
    idx_t           sel;
    logic [IDX_W:0] j;
    hit = 1'b0;
    sel = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      j = {1'b0, start} + (IDX_W+1)'(off);
      if (j >= (IDX_W+1)'(NUM_PORTS)) j = j - (IDX_W+1)'(NUM_PORTS);
      if (!hit && e[j[IDX_W-1:0]]) begin
        hit = 1'b1;
        sel = j[IDX_W-1:0];
      end
    end
    return {hit, sel};
  endfunction

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_timer
    arb_port_timer #(
      .LEN_W     (LEN_W),
      .ID_W      (ID_W),
      .HEADER_ID (HEADER_ID)
    ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .flit_id (bus.flit_id[p*ID_W +: ID_W]),
      .length  (bus.length[p*LEN_W +: LEN_W]),
      .run     (grant_q[p]),
      .expired (expired[p])
    );
  end

  // ptr_q always names the holder while a grant is active, so it doubles as
  // the current index and as the scan origin in both IDLE and HOLD.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    elig          = bus.req & ~(grant_q & expired);
    {found, pick} = rr_pick(elig, ptr_q);
    keep          = (|grant_q) && bus.req[ptr_q] && !expired[ptr_q];
    grant_d       = '0;
    ptr_d         = ptr_q;
    if (keep) begin
      grant_d = grant_q;
    end else if (found) begin
      grant_d[pick] = 1'b1;
      ptr_d         = pick;
    end
  end

  always_comb begin
    timeout_d = grant_q & ~grant_d & expired & bus.req;
  end

  // NOTE: reset is synchronous; the pointer restarts at the last port so the
  // first scan after reset begins at port 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q   <= '0;
      timeout_q <= '0;
      ptr_q     <= idx_t'(NUM_PORTS-1);
    end else begin
      grant_q   <= grant_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_valid   = |grant_q;
  assign bus.grant_idx     = (|grant_q) ? ptr_q : '0;
  assign bus.timeout_pulse = timeout_q;

endmodule
